// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges PS/2 key state and HPS joysticks into registered per-player controls, coin stretch and pause toggle
module arcade_input_ctrl #(
  parameter int COIN_CYCLES = 16,
  parameter int CW = 20
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  output logic [8:0]  p1_ctrl,
  output logic [8:0]  p2_ctrl,
  output logic [1:0]  service,
  output logic        pause
);
  logic          tog_q, armed, ev, pause_raw, pause_raw_q, unused;
  logic [7:0]    code;
  logic [10:0]   hit1, hit2, k1, k2, raw1, raw2;
  logic [1:0]    coin_q;
  logic [CW-1:0] cnt1, cnt2, cnt1_d, cnt2_d;
  function automatic logic [7:0] dirs(input logic [10:0] r);
    return {r[7], r[6], r[5], r[4], r[0], r[1], r[2], r[3]};
  endfunction
  assign code = ps2_key[7:0];
  assign ev = armed & (ps2_key[10] != tog_q);
  assign hit1 = {code == 8'h46, code == 8'h4D, code == 8'h2E, code == 8'h16, code == 8'h29, code == 8'h11,
                 code == 8'h14, code == 8'h75, code == 8'h72, code == 8'h6B, code == 8'h74};
  assign hit2 = {code == 8'h45, 1'b0, code == 8'h36, code == 8'h1E, code == 8'h15, code == 8'h1B,
                 code == 8'h1C, code == 8'h2D, code == 8'h2B, code == 8'h23, code == 8'h34};
  assign raw1 = k1 | joystick_0[10:0];
  assign raw2 = k2 | joystick_1[10:0];
  assign pause_raw = raw1[9] | raw2[9];
  assign cnt1_d = (raw1[8] & ~coin_q[0]) ? CW'(COIN_CYCLES - 1) : (cnt1 != 0) ? cnt1 - CW'(1) : cnt1;
  assign cnt2_d = (raw2[8] & ~coin_q[1]) ? CW'(COIN_CYCLES - 1) : (cnt2 != 0) ? cnt2 - CW'(1) : cnt2;
  assign unused = ^{joystick_0[31:11], joystick_1[31:11], ps2_key[8]};
  // key latches, edge detectors, coin stretchers and registered outputs
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) begin
      tog_q       <= 1'b0;
      armed       <= 1'b0;
      k1          <= '0;
      k2          <= '0;
      coin_q      <= '0;
      cnt1        <= '0;
      cnt2        <= '0;
      pause_raw_q <= 1'b0;
      p1_ctrl     <= '0;
      p2_ctrl     <= '0;
      service     <= '0;
      pause       <= 1'b0;
    end else begin
      tog_q       <= ps2_key[10];
      armed       <= 1'b1;
      k1          <= ev ? (ps2_key[9] ? k1 | hit1 : k1 & ~hit1) : k1;
      k2          <= ev ? (ps2_key[9] ? k2 | hit2 : k2 & ~hit2) : k2;
      coin_q      <= {raw2[8], raw1[8]};
      cnt1        <= cnt1_d;
      cnt2        <= cnt2_d;
      pause_raw_q <= pause_raw;
      p1_ctrl     <= {raw1[8] | (cnt1 != 0), dirs(raw1)};
      p2_ctrl     <= {raw2[8] | (cnt2 != 0), dirs(raw2)};
      service     <= {raw2[10], raw1[10]};
      pause       <= pause ^ (pause_raw & ~pause_raw_q);
    end
endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Sits between hps_io and the Main core in clk_sys.
- Decodes the 11-bit ps2_key event word into held-key state and merges it with joystick_0 and joystick_1 into registered per-player control vectors.
- Stretches coin pulses to a guaranteed minimum width and turns either player's pause button into a pause toggle.
- Replaces the ad hoc key decoding and joystick OR logic in emu.

Parameters:
- COIN_CYCLES, 16, minimum coin output high time in clk_sys cycles; legal range 1..2^CW-1.
- CW, 20, width of the coin stretch counters.

Ports:
- clk_sys  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
- joystick_0  in  32  player 1 HPS joystick: [0]R [1]L [2]D [3]U [4..6]B1..B3 [7]start [8]coin [9]pause [10]service.
- joystick_1  in  32  player 2, same layout.
- p1_ctrl  out  9  {coin, start, b3, b2, b1, right, left, down, up}.
- p2_ctrl  out  9  same layout as p1_ctrl.
- service  out  2  {service2, service1}.
- pause  out  1  pause latch.

Behaviour:
- Reset: every key latch, p1_ctrl, p2_ctrl, service and pause = 0; coin counters = 0; armed = 0; tog_q = 0.
- Toggle capture: tog_q <= ps2_key[10] every cycle.
- First cycle after reset: armed <= 1 and no decode, so a stale toggle value is never taken as an event.
- Event condition: armed & (ps2_key[10] != tog_q). On the next edge the matching key latch <= ps2_key[9].
- Decode ignores ps2_key[8].
- Unlisted scan codes: no effect.
- Only one event per toggle change. A held toggle produces no repeat.
- Key map:
  - 75 up, 72 down, 6B left, 74 right.
  - 14 P1 b1, 11 P1 b2, 29 P1 b3.
  - 16 P1 start, 1E P2 start, 2E P1 coin, 36 P2 coin.
  - 4D P1 pause.
  - 46 service1, 45 service2.
  - 2D P2 up, 2B P2 down, 23 P2 left, 34 P2 right.
  - 1C P2 b1, 1B P2 b2, 15 P2 b3.
- Raw input: raw = key latch | joystick bit. P2 pause is joystick_1[9] only.
- Direction, button and start outputs: registered copy of raw.
  - Latency is 1 cycle from a joystick change.
  - Latency is 2 cycles from a ps2_key toggle change (latch, then output register).
- Coin stretcher, per player, raw_coin delayed 1 cycle as coin_q:
  - On a rising edge of raw_coin, cnt <= COIN_CYCLES-1.
  - Else if cnt != 0, cnt <= cnt-1.
  - Output register coin <= raw_coin | (cnt != 0).
  - Output stays high for max(COIN_CYCLES, input high time) cycles.
  - A retrigger while cnt != 0 reloads cnt.
  - Counter saturates at 0 and does not wrap.
- Pause:
  - pause_raw = P1 pause raw | P2 pause raw.
  - On the rising edge (pause_raw & ~pause_raw_q), pause <= ~pause, registered, 1 cycle.
  - Both players pressing in the same cycle gives a single toggle.
  - A held button gives no further toggles.
- service: registered raw, 1 cycle.
- Simultaneous key event and joystick change on the same bit: OR semantics, no priority.
- Reset mid-stretch or mid-pause: all state clears immediately and asynchronously. After deassertion the first cycle is unarmed.

Test Plan:
- Reset with ps2_key[10]=1 held, then release RESET with no toggle change -> all outputs stay 0 for 10 cycles and no key latch sets.
- ps2_key toggles with pressed=1, code 75 -> p1_ctrl[0]=1 exactly 2 cycles later. Toggle again with pressed=0, code 75 -> p1_ctrl[0]=0 2 cycles after that.
- COIN_CYCLES=8; joystick_0[8] high for 1 cycle -> p1_ctrl[8] high exactly 8 cycles. Input held 20 cycles -> output high 20 cycles. Retrigger at output cycle 5 -> output high 13 cycles total.
- Press P1 key_p, release, then pulse joystick_1[9] -> pause goes 0→1→0. joystick_0[9] and joystick_1[9] rising in the same cycle -> exactly one toggle.
- Key 2D latched pressed while joystick_1[3] pulses 0→1→0 -> p2_ctrl[0] stays 1 throughout. Codes with the ps2_key[8]=1 variant decode identically.
- Assert RESET during a coin stretch with cnt=5 -> p1_ctrl[8]=0 immediately and no resumption after release.
